// File: rtl/mem_size_scan_display.sv
// Memory-size indicator: binary MB count -> BCD via sequential double-dabble, shown on a scanned N-digit display (LAMP_TEST port with MEM_SIZE_LAMP_TEST_EN).
// Latency: display register reloads MB_W+2 cycles after a new size is seen, outputs follow one cycle later; no backpressure, the scan free-runs.
module mem_size_scan_display #(
    parameter int NDIGITS  = 3,
    parameter int MB_W     = 8,
    parameter int PRESCALE = 16
) (
    input  logic               CK,
    input  logic               RST,
    input  logic [MB_W-1:0]    MSIZE_MB,
    input  logic               MOFF,
`ifdef MEM_SIZE_LAMP_TEST_EN
    input  logic               LAMP_TEST,
`endif
    output logic [NDIGITS-1:0] DIGIT_EN_n,
    output logic [3:0]         BCD,
    output logic               BLANK,
    output logic               OVF,
    output logic               BUSY
);

    // Number of decimal digits needed to hold 2^w-1.
    function automatic int calc_nbcd(input int w);
        logic [63:0] v;
        int          n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    localparam int NBCD = calc_nbcd(MB_W);
    localparam int NX   = (NBCD > NDIGITS) ? NBCD : NDIGITS;
    localparam int BW   = 4 * NBCD;
    localparam int CW   = $clog2(MB_W + 1);
    localparam int IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [MB_W-1:0]        cap_q, cap_d;
    logic [MB_W-1:0]        bin_q, bin_d;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic                   carry_q, carry_d;
    logic [MB_W-1:0]        last_q, last_d;
    logic                   force_q, force_d;
    logic [4*NDIGITS-1:0]   disp_q, disp_d;
    logic                   vld_q, vld_d;
    logic                   ovf_q, ovf_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NDIGITS-1:0]     en_q, en_d;
    logic [3:0]             bcdo_q, bcdo_d;
    logic                   blank_q, blank_d;
    logic                   ovfo_q, ovfo_d;

    logic [BW-1:0]          adj;
    logic [4*NX-1:0]        bcd_ext;
    logic                   hi_nz;
    logic                   ovf_now;
    logic                   busy;
    logic                   upper_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        carry_d = carry_q;
        last_d  = last_q;
        force_d = force_q;
        disp_d  = disp_q;
        vld_d   = vld_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        ovf_now = 1'b0;
        adj     = bcd_q;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        // Digits beyond the display width only feed the overflow decision.
        bcd_ext = (4*NX)'(bcd_q);
        hi_nz   = (bcd_ext >> (4 * NDIGITS)) != '0;

        case (state_q)
            IDLE: begin
                if ((MSIZE_MB != last_q) || force_q) begin
                    busy    = 1'b1;
                    cap_d   = MSIZE_MB;
                    bin_d   = MSIZE_MB;
                    bcd_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    force_d = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                busy    = 1'b1;
                bcd_d   = {adj[BW-2:0], bin_q[MB_W-1]};
                carry_d = carry_q | adj[BW-1];
                bin_d   = bin_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(MB_W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                ovf_now = hi_nz | carry_q;
                ovf_d   = ovf_now;
                disp_d  = ovf_now ? {NDIGITS{4'h9}} : bcd_ext[4*NDIGITS-1:0];
                vld_d   = 1'b1;
                last_d  = cap_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(PRESCALE - 1)) begin
            presc_d = '0;
            if (idx_q == IW'(NDIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        upper_zero = 1'b1;
        en_d       = '1;
        bcdo_d     = 4'h0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((i >= int'(idx_q)) && (disp_q[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
            if (i == int'(idx_q)) begin
                en_d[i] = 1'b0;
                bcdo_d  = disp_q[4*i +: 4];
            end
        end
        // Digit 0 is exempt from leading-zero blanking so 0 MB reads "0".
        blank_d = MOFF | ~vld_q | ((idx_q != '0) & upper_zero);
        ovfo_d  = ovf_q;
        if (MOFF) begin
            bcdo_d = 4'hF;
        end
`ifdef MEM_SIZE_LAMP_TEST_EN
        if (LAMP_TEST) begin
            bcdo_d  = 4'h8;
            blank_d = 1'b0;
            ovfo_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            last_q  <= '0;
            force_q <= 1'b1;
            disp_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            en_q    <= '1;
            bcdo_q  <= 4'h0;
            blank_q <= 1'b1;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            last_q  <= last_d;
            force_q <= force_d;
            disp_q  <= disp_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            bcdo_q  <= bcdo_d;
            blank_q <= blank_d;
            ovfo_q  <= ovfo_d;
        end
    end

    assign DIGIT_EN_n = en_q;
    assign BCD        = bcdo_q;
    assign BLANK      = blank_q;
    assign OVF        = ovfo_q;
    assign BUSY       = busy & ~RST;

endmodule

// File: tb/tb_mem_size_scan_display.sv
// Bench for mem_size_scan_display: default, 2-digit and PRESCALE=1 instances checked against a decimal-arithmetic scoreboard.
module tb_mem_size_scan_display;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic       rst0, rst1, rst2;
    logic [7:0] msz0, msz1, msz2;
    logic       moff0, moff1, moff2;
    logic [2:0] en0, en2;
    logic [1:0] en1;
    logic [3:0] bcd0, bcd1, bcd2;
    logic       blank0, blank1, blank2;
    logic       ovf0, ovf1, ovf2;
    logic       busy0, busy1, busy2;
`ifdef MEM_SIZE_LAMP_TEST_EN
    logic       lamp0, lamp_off;
`endif

    mem_size_scan_display u0 (
        .CK(CK), .RST(rst0), .MSIZE_MB(msz0), .MOFF(moff0),
`ifdef MEM_SIZE_LAMP_TEST_EN
        .LAMP_TEST(lamp0),
`endif
        .DIGIT_EN_n(en0), .BCD(bcd0), .BLANK(blank0), .OVF(ovf0), .BUSY(busy0)
    );

    mem_size_scan_display #(.NDIGITS(2), .PRESCALE(4)) u1 (
        .CK(CK), .RST(rst1), .MSIZE_MB(msz1), .MOFF(moff1),
`ifdef MEM_SIZE_LAMP_TEST_EN
        .LAMP_TEST(lamp_off),
`endif
        .DIGIT_EN_n(en1), .BCD(bcd1), .BLANK(blank1), .OVF(ovf1), .BUSY(busy1)
    );

    mem_size_scan_display #(.PRESCALE(1)) u2 (
        .CK(CK), .RST(rst2), .MSIZE_MB(msz2), .MOFF(moff2),
`ifdef MEM_SIZE_LAMP_TEST_EN
        .LAMP_TEST(lamp_off),
`endif
        .DIGIT_EN_n(en2), .BCD(bcd2), .BLANK(blank2), .OVF(ovf2), .BUSY(busy2)
    );

    int         sel;
    logic [5:0] m_en;
    logic [3:0] m_bcd;
    logic       m_blank, m_ovf, m_busy;

    always_comb begin
        case (sel)
            1: begin
                m_en = {4'b0, en1}; m_bcd = bcd1; m_blank = blank1; m_ovf = ovf1; m_busy = busy1;
            end
            2: begin
                m_en = {3'b0, en2}; m_bcd = bcd2; m_blank = blank2; m_ovf = ovf2; m_busy = busy2;
            end
            default: begin
                m_en = {3'b0, en0}; m_bcd = bcd0; m_blank = blank0; m_ovf = ovf0; m_busy = busy0;
            end
        endcase
    end

    typedef struct {
        int v;
        bit moff;
        bit lamp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_checks++;
        n_err++;
        $error("FAIL %s: observed nothing, expected the event within its bound", tag);
    endtask

    task automatic step();
        @(negedge CK);
        #1;
    endtask

    function automatic int p10(input int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    // Waits for BUSY to rise, then returns how many sampled cycles it stayed high.
    task automatic run_conv(input string tag, output int n);
        int w;
        n = 0;
        w = 0;
        #1;
        while (!m_busy && w < 40) begin
            step();
            w++;
        end
        if (!m_busy) begin
            fail({tag, " busy rise"});
            return;
        end
        while (m_busy && n < 200) begin
            n++;
            step();
        end
    endtask

    // Pops one expected display state and checks every digit slot of the selected instance.
    task automatic scan_check(input string tag);
        exp_t e;
        int   nd, pr, seen, run, chg, prev, cur, pv, dig, blk, ovf;
        if (sb.size() == 0) begin
            fail({tag, " scoreboard entry"});
            return;
        end
        e    = sb.pop_front();
        nd   = (sel == 1) ? 2 : 3;
        pr   = (sel == 1) ? 4 : ((sel == 2) ? 1 : 16);
        ovf  = (e.v >= p10(nd)) ? 1 : 0;
        seen = 0;
        run  = 0;
        chg  = 0;
        prev = -1;
        step();
        step();
        for (int c = 0; c < nd * pr * 3 + 10 && seen != (1 << nd) - 1; c++) begin
            cur = -1;
            for (int k = 0; k < nd; k++) begin
                if (int'(m_en) == (((1 << nd) - 1) & ~(1 << k))) cur = k;
            end
            if (cur < 0) begin
                fail({tag, " one-hot digit enable"});
            end else begin
                if (prev >= 0 && cur != prev) begin
                    chk({tag, " scan order"}, cur, (prev + 1) % nd);
                    if (chg != 0) chk({tag, " slot length"}, run, pr);
                    chg = 1;
                    run = 0;
                end
                run++;
                prev = cur;
                if (((seen >> cur) & 1) == 0) begin
                    pv  = p10(cur);
                    dig = (ovf != 0) ? 9 : (e.v / pv) % 10;
                    blk = (cur > 0 && ovf == 0 && e.v / pv == 0) ? 1 : 0;
                    if (e.lamp) begin
                        dig = 8;
                        blk = 0;
                    end else if (e.moff) begin
                        dig = 15;
                        blk = 1;
                    end
                    chk($sformatf("%s digit%0d bcd", tag, cur), m_bcd, dig);
                    chk($sformatf("%s digit%0d blank", tag, cur), m_blank, blk);
                    seen = seen | (1 << cur);
                end
            end
            step();
        end
        chk({tag, " digits covered"}, seen, (1 << nd) - 1);
        chk({tag, " ovf"}, m_ovf, e.lamp ? 1 : ovf);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, seen4, bad;
        sel   = 0;
        rst0  = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        msz0  = 8'd6; msz1 = 8'd0; msz2 = 8'd0;
        moff0 = 1'b0; moff1 = 1'b0; moff2 = 1'b0;
`ifdef MEM_SIZE_LAMP_TEST_EN
        lamp0 = 1'b0; lamp_off = 1'b0;
`endif
        repeat (3) step();
        chk("reset digit_en", m_en, 6'b000111);
        chk("reset bcd", m_bcd, 0);
        chk("reset blank", m_blank, 1);
        chk("reset ovf", m_ovf, 0);
        chk("reset busy", m_busy, 0);

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        sb.push_back('{6, 1'b0, 1'b0});
        run_conv("conv 6", n);
        chk("busy cycles 6", n, 10);
        scan_check("show 6");

        msz0 = 8'd128;
        sb.push_back('{128, 1'b0, 1'b0});
        run_conv("conv 128", n);
        chk("busy cycles 128", n, 10);
        scan_check("show 128");

        moff0 = 1'b1;
        sb.push_back('{128, 1'b1, 1'b0});
        step();
        chk("moff next blank", m_blank, 1);
        chk("moff next bcd", m_bcd, 4'hF);
        chk("moff no conversion", m_busy, 0);
        scan_check("moff on");
        moff0 = 1'b0;
        sb.push_back('{128, 1'b0, 1'b0});
        #1;
        chk("moff release no conversion", m_busy, 0);
        scan_check("moff off");

        msz0 = 8'd0;
        sb.push_back('{0, 1'b0, 1'b0});
        run_conv("conv 0", n);
        chk("busy cycles 0", n, 10);
        scan_check("show 0");

`ifdef MEM_SIZE_LAMP_TEST_EN
        lamp0 = 1'b1;
        sb.push_back('{0, 1'b0, 1'b1});
        scan_check("lamp on");
        lamp0 = 1'b0;
        sb.push_back('{0, 1'b0, 1'b0});
        scan_check("lamp off");
`endif

        sel  = 1;
        msz1 = 8'd255;
        sb.push_back('{255, 1'b0, 1'b0});
        run_conv("conv 255", n);
        chk("busy cycles 255", n, 10);
        scan_check("2dig 255");
        msz1 = 8'd42;
        sb.push_back('{42, 1'b0, 1'b0});
        run_conv("conv 42", n);
        chk("busy cycles 42", n, 10);
        scan_check("2dig 42");

        // Size changes to 6 on the third CONV cycle of the 0->4 conversion.
        sel   = 2;
        msz2  = 8'd4;
        seen4 = 0;
        bad   = 0;
        n     = 0;
        #1;
        chk("change start busy", m_busy, 1);
        while (m_busy && n < 100) begin
            if (n == 3) msz2 = 8'd6;
            if (m_en == 6'b000110 && !m_blank) begin
                if (m_bcd == 4'd4) seen4 = 1;
                else if (m_bcd != 4'd0) bad++;
            end
            n++;
            step();
        end
        chk("change busy cycles", n, 20);
        chk("change showed 4", seen4, 1);
        chk("change no other value", bad, 0);
        sb.push_back('{6, 1'b0, 1'b0});
        scan_check("change shows 6");

        msz2 = 8'd200;
        repeat (4) step();
        rst2 = 1'b1;
        step();
        chk("midconv reset digit_en", m_en, 6'b000111);
        chk("midconv reset bcd", m_bcd, 0);
        chk("midconv reset blank", m_blank, 1);
        chk("midconv reset ovf", m_ovf, 0);
        chk("midconv reset busy", m_busy, 0);
        rst2 = 1'b0;
        sb.push_back('{200, 1'b0, 1'b0});
        run_conv("conv after reset", n);
        chk("busy cycles after reset", n, 10);
        scan_check("show 200");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_size_scan_display.md
Name: mem_size_scan_display

Overview:
- Parametrised memory-size indicator for the RAM array board.
- Converts a binary megabyte count to BCD using a sequential double-dabble converter.
- Drives an N-digit multiplexed display: one-hot active-low digit enables plus a BCD nibble, scanned LSB to MSB.
- Generalises the fixed three-digit, four-size PAL indicator: any size up to 2^MB_W-1 MB, any digit count, programmable scan rate, leading-zero blanking and an overflow flag.

Parameters:
- NDIGITS, 3: number of display digits, 1..6.
- MB_W, 8: width of the megabyte count input.
- PRESCALE, 16: CK cycles per digit slot, minimum 1.

Ports:
- CK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- MSIZE_MB  input  MB_W  installed memory in MB, unsigned binary.
- MOFF  input  1  memory disabled; blanks the whole display.
- DIGIT_EN_n  output  NDIGITS  one-hot active-low digit enable; bit 0 is the least significant digit.
- BCD  output  4  BCD value for the enabled digit.
- BLANK  output  1  high means the enabled digit must be dark.
- OVF  output  1  value exceeds 10^NDIGITS-1; display saturated.
- BUSY  output  1  conversion in progress.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it wins over every other input.
- Reset values:
  - DIGIT_EN_n all ones, BCD 0, BLANK 1, OVF 0, BUSY 0.
  - Scan index 0, prescaler 0.
  - Display register all-zero with its "valid" bit cleared, so every digit is blanked.
  - Last-converted register cleared; a conversion is forced in the first cycle after reset.
- Converter FSM, states IDLE, CONV, LOAD:
  - IDLE: if MSIZE_MB differs from last-converted, or a forced conversion is pending, capture MSIZE_MB, clear the shift register, go to CONV and set BUSY.
  - CONV: exactly MB_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit, MSB of the captured value first.
  - LOAD: 1 cycle.
    - Copy the BCD nibbles into the display register and set valid.
    - Set OVF if any BCD digit above NDIGITS-1 is non-zero, or a carry leaves the top nibble. When OVF is set, load all 9s.
    - Update last-converted with the captured value. Clear BUSY. Return to IDLE.
  - Latency: display register is updated MB_W+2 cycles after the capture edge.
  - A change on MSIZE_MB during CONV or LOAD does not abort the conversion. IDLE detects the mismatch on the following cycle and starts a new conversion.
  - The BCD working width is the minimum needed for MB_W bits; the nibbles beyond NDIGITS are used only for OVF.
- Scanner:
  - The prescaler counts 0..PRESCALE-1.
  - On the wrap cycle, the scan index advances, wrapping from NDIGITS-1 to 0.
  - With PRESCALE=1 the index advances every cycle.
  - NDIGITS=1: the index stays at 0 and DIGIT_EN_n is held at 0.
- Outputs are registered, one cycle after the index or display register changes:
  - DIGIT_EN_n: bit[index] is 0, all other bits are 1.
  - BCD: display nibble[index].
  - BLANK is 1 if any of the following holds:
    - MOFF is 1.
    - Display register is not valid.
    - index > 0 and nibbles index..NDIGITS-1 are all zero (leading-zero blanking; digit 0 is never blanked this way, so 0 MB shows "0").
  - While MOFF is 1, BCD is forced to 4'hF. The scan continues and conversion is unaffected.
- The display register holds its old value during conversion, so there is no flicker of partial results.

Optional Feature:
- Macro: MEM_SIZE_LAMP_TEST_EN.
- Defined:
  - Adds input port LAMP_TEST (1 bit).
  - While LAMP_TEST is high: BCD=8, BLANK=0 and OVF=1 on the outputs, overriding MOFF and blanking.
  - Scanning continues; the internal display register and OVF state are unaffected.
  - Release restores normal output on the next registered update.
- Not defined: no LAMP_TEST port and no override logic.

Test Plan:
- Reset then release with MSIZE_MB=6, MOFF=0, defaults. Required response:
  - BUSY high for MB_W+2=10 cycles.
  - Then digit 0 shows BCD=6, BLANK=0.
  - Digits 1 and 2 show BLANK=1.
  - DIGIT_EN_n steps 110,101,011 every 16 cycles.
- MSIZE_MB=128. Required response: digits 0,1,2 show 8,2,1, all unblanked, OVF=0. MSIZE_MB=0: digit 0 shows 0 unblanked, digits 1 and 2 blanked.
- Change MSIZE_MB from 4 to 6 at the third CONV cycle. Required response:
  - First LOAD shows 4.
  - IDLE restarts the next cycle.
  - 6 is displayed 10 cycles later.
  - No intermediate value appears.
- NDIGITS=2, MSIZE_MB=255. Required response: OVF=1 and both digits show 9. Then MSIZE_MB=42: OVF=0 and digits show 2,4.
- MOFF=1 mid-scan. Required response: next cycle BLANK=1 and BCD=4'hF on every slot, DIGIT_EN_n still rotating. MOFF=0: the prior value reappears without reconversion.
- PRESCALE=1 with RST asserted mid-CONV. Required response: next cycle all outputs at reset values, then a fresh conversion starts. With MEM_SIZE_LAMP_TEST_EN defined, LAMP_TEST=1 gives BCD=8, BLANK=0 on all digits.
